// File: rtl/store_unit_if.sv
// store_unit_if: store request / memory write bus between execute stage, store unit and data memory.
// Request side: req_valid/req_ready handshake carrying req_addr, req_data, req_size.
// Memory side:  mem_wvalid/mem_wready handshake carrying mem_addr, mem_wdata, mem_wstrb.
// Status:       done/err one-cycle pulses, err_code, busy.
// master = requester and memory model, slave = store unit.
interface store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic        busy;

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_wready,
        input  req_ready, mem_wvalid, mem_addr, mem_wdata, mem_wstrb, done, err, err_code, busy
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_wready,
        output req_ready, mem_wvalid, mem_addr, mem_wdata, mem_wstrb, done, err, err_code, busy
    );
endinterface

// File: rtl/store_unit.sv
// store_unit: store-path formatter and memory write master.
// Ports: clk, rst_n (async active-low), bus (store_unit_if.slave).
// Accepts one byte/halfword/word store, checks alignment, replicates data onto
// byte lanes with strobes, writes to memory with a TIMEOUT-bounded wait and
// reports completion (done) or rejection/abandonment (err, err_code).
module store_unit #(
    parameter int TIMEOUT = 15
) (
    input logic         clk,
    input logic         rst_n,
    store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WRITE, DONE, ERR} state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [1:0]  code;
    logic [1:0]  off;
    logic        bad_size;
    logic        misaligned;
    logic [31:0] lane_data;
    logic [3:0]  lane_strb;

    always_comb begin
        off        = bus.req_addr[1:0];
        bad_size   = bus.req_size == 2'b11;
        misaligned = (bus.req_size == 2'b01 && off[0]) || (bus.req_size == 2'b10 && off != 2'b00);
        lane_data  = bus.req_size == 2'b00 ? {4{bus.req_data[7:0]}} :
                     bus.req_size == 2'b01 ? {2{bus.req_data[15:0]}} : bus.req_data;
        lane_strb  = bus.req_size == 2'b00 ? 4'b0001 << off :
                     bus.req_size == 2'b01 ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    end

    // Decoded from state so an asynchronous reset drops wvalid at once.
    assign bus.mem_wvalid = state == WRITE;
    assign bus.done       = state == DONE;
    assign bus.err        = state == ERR;
    assign bus.busy       = state != IDLE;
    assign bus.err_code   = bus.err ? code : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            code          <= '0;
            bus.req_ready <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_wstrb <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        bus.req_ready <= 1'b0;
                        if (bad_size || misaligned) begin
                            state <= ERR;
                            code  <= bad_size ? 2'b10 : 2'b01;
                        end else begin
                            state         <= WRITE;
                            cnt           <= '0;
                            bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
                            bus.mem_wdata <= lane_data;
                            bus.mem_wstrb <= lane_strb;
                        end
                    end else begin
                        bus.req_ready <= 1'b1;
                    end
                end
                WRITE: begin
                    if (bus.mem_wready) begin
                        state <= DONE;
                    end else if (cnt == 8'(TIMEOUT - 1)) begin
                        state <= ERR;
                        code  <= 2'b11;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed self-checking bench for store_unit with a
// transaction-level model of expected outputs per cycle after acceptance.
module tb_store_unit;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    store_unit_if bus();
    store_unit #(.TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_cyc = 0;
    bit active = 1'b0;
    bit tie = 1'b0;

    bit          m_legal;
    bit          m_to;
    logic [1:0]  m_code;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    int          m_n;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Expected outcome of one store from the architectural rules.
    task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s, input int w);
        int nb;
        logic [63:0] v;
        nb      = 1 << s;
        m_legal = s != 2'b11 && (a % nb) == 0;
        m_to    = m_legal && w >= TO;
        m_code  = s == 2'b11 ? 2'd2 : !m_legal ? 2'd1 : m_to ? 2'd3 : 2'd0;
        m_addr  = a & ~32'd3;
        v       = {32'd0, d} & ((64'd1 << (8 * nb)) - 64'd1);
        m_wdata = '0;
        for (int i = 0; i < 4 / nb; i++) m_wdata |= 32'(v << (8 * nb * i));
        m_wstrb = 4'(((1 << nb) - 1) << (a % 4));
        m_n     = !m_legal ? 0 : (w < TO ? w + 1 : TO);
    endtask

    // Per-cycle comparison; k=1 is the cycle right after the accepting edge.
    always @(negedge clk) if (active) begin : cmp
        int k;
        bit e_wv;
        bit e_err;
        k     = cyc - acc_cyc + 1;
        e_wv  = m_legal && k <= m_n;
        e_err = (!m_legal && k == 1) || (m_to && k == m_n + 1);
        chk("wvalid", 32'(bus.mem_wvalid), 32'(e_wv));
        chk("done", 32'(bus.done), 32'(m_legal && !m_to && k == m_n + 1));
        chk("err", 32'(bus.err), 32'(e_err));
        chk("err_code", 32'(bus.err_code), 32'(e_err ? m_code : 2'd0));
        chk("req_ready", 32'(bus.req_ready), 32'(k >= m_n + 2));
        chk("busy", 32'(bus.busy), 32'(k <= m_n + 1));
        if (e_wv) begin
            chk("mem_addr", bus.mem_addr, m_addr);
            chk("mem_wdata", bus.mem_wdata, m_wdata);
            chk("mem_wstrb", 32'(bus.mem_wstrb), 32'(m_wstrb));
        end
    end

    task automatic idle_outputs(input string tag, input bit ready);
        chk({tag, "_wvalid"}, 32'(bus.mem_wvalid), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_err"}, 32'(bus.err), 32'd0);
        chk({tag, "_code"}, 32'(bus.err_code), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'(ready));
    endtask

    // Called #1 after an edge. w = wait cycles before wready (>=TO: never);
    // rst_k > 0 pulls reset in cycle rst_k of the transaction.
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                         input int w, input int rst_k);
        bit ab;
        ab = 1'b0;
        model(a, d, s, w);
        chk("accept_ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_data  = d;
        bus.req_size  = s;
        @(posedge clk); #1;
        acc_cyc       = cyc;
        active        = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_data  = 32'hFFFF_FFFF;
        bus.req_size  = 2'b11;
        for (int k = 1; k <= m_n + 2 && !ab; k++) begin
            bus.mem_wready = tie || (m_legal && k == w + 1);
            if (k == rst_k) begin
                ab = 1'b1;
                chk("pre_rst_wvalid", 32'(bus.mem_wvalid), 32'd1);
                #2;
                rst_n  = 1'b0;
                active = 1'b0;
                #1;
                idle_outputs("rst_now", 1'b0);
                chk("rst_now_wstrb", 32'(bus.mem_wstrb), 32'd0);
                @(posedge clk); #1;
                idle_outputs("rst_hold", 1'b0);
                rst_n = 1'b1;
                #1;
                chk("rel_ready_low", 32'(bus.req_ready), 32'd0);
                @(posedge clk); #1;
                idle_outputs("rel_edge", 1'b1);
            end else begin
                @(posedge clk); #1;
            end
        end
        active         = 1'b0;
        bus.mem_wready = tie;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.req_data   = '0;
        bus.req_size   = '0;
        bus.mem_wready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle_outputs("reset", 1'b0);
        chk("reset_addr", bus.mem_addr, 32'd0);
        chk("reset_wdata", bus.mem_wdata, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("release_ready_low", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        idle_outputs("first_edge", 1'b1);

        // Hand-computed pins on the model itself.
        model(32'h1003, 32'hDEADBE7F, 2'b00, 0);
        chk("pin_b_addr", m_addr, 32'h1000);
        chk("pin_b_wdata", m_wdata, 32'h7F7F7F7F);
        chk("pin_b_strb", 32'(m_wstrb), 32'b1000);
        chk("pin_b_n", 32'(m_n), 32'd1);
        model(32'h2002, 32'h0000ABCD, 2'b01, 0);
        chk("pin_h_wdata", m_wdata, 32'hABCDABCD);
        chk("pin_h_strb", 32'(m_wstrb), 32'b1100);
        model(32'h3002, 32'h0, 2'b10, 0);
        chk("pin_mis_code", 32'(m_code), 32'd1);
        model(32'h3000, 32'h0, 2'b11, 0);
        chk("pin_size_code", 32'(m_code), 32'd2);
        model(32'h6000, 32'h0, 2'b10, 100);
        chk("pin_to_n", 32'(m_n), 32'd15);
        chk("pin_to_code", 32'(m_code), 32'd3);

        tie = 1'b1;
        bus.mem_wready = 1'b1;
        store(32'h1003, 32'hDEADBE7F, 2'b00, 0, 0);
        store(32'h2002, 32'h0000ABCD, 2'b01, 0, 0);
        store(32'h2004, 32'h12345678, 2'b10, 0, 0);
        store(32'h0041, 32'h000000A5, 2'b00, 0, 0);
        store(32'h0040, 32'h9876FEDC, 2'b01, 0, 0);
        store(32'h3002, 32'h11111111, 2'b10, 0, 0);
        store(32'h3001, 32'h22222222, 2'b01, 0, 0);
        store(32'h3000, 32'h33333333, 2'b11, 0, 0);

        tie = 1'b0;
        bus.mem_wready = 1'b0;
        store(32'h5008, 32'hCAFEF00D, 2'b10, 4, 0);
        store(32'h6000, 32'h11223344, 2'b10, 100, 0);
        store(32'h6004, 32'h55667788, 2'b10, 14, 0);
        store(32'h7001, 32'h00000055, 2'b00, 100, 3);
        store(32'h7002, 32'h00000066, 2'b00, 0, 0);
        idle_outputs("end", 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
